axi4lite_reg_slave: RTL and testbench
=====================================

// Module: axi4lite_reg_slave
// PURPOSE
//  AXI4-Lite slave register bank; the responder for the team's AXI4-Lite bus-master FSMs.
//  Maps NUM_REGS 32-bit words at BASE_ADDR: word 0 = read-only STATUS_IN, words 1..NUM_REGS-1 R/W.
//  Word 5 (BASE_ADDR+0x14) is the control/state register that the master's button sequence writes.
//  Exposes all register contents and per-word write strobes to fabric logic.
// PARAMETERS
//  AXI_DATA_WIDTH  32            data width; only 32 is supported
//  AXI_ADDR_WIDTH  32            address width
//  BASE_ADDR       32'h0000_1000 byte address of word 0
//  NUM_REGS        8             number of words, 2..16
// PORTS
//  S_AXI_ACLK     in   1          clock
//  S_AXI_ARESETN  in   1          asynchronous, active-low reset
//  S_AXI_AWADDR   in   ADDR       write address
//  S_AXI_AWVALID  in   1          write-address valid
//  S_AXI_AWREADY  out  1          write-address ready
//  S_AXI_AWPROT   in   3          ignored
//  S_AXI_WDATA    in   DATA       write data
//  S_AXI_WSTRB    in   DATA/8     byte-lane enables
//  S_AXI_WVALID   in   1          write-data valid
//  S_AXI_WREADY   out  1          write-data ready
//  S_AXI_BRESP    out  2          00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out  1          write-response valid
//  S_AXI_BREADY   in   1          write-response ready
//  S_AXI_ARADDR   in   ADDR       read address
//  S_AXI_ARVALID  in   1          read-address valid
//  S_AXI_ARREADY  out  1          read-address ready
//  S_AXI_ARPROT   in   3          ignored
//  S_AXI_RDATA    out  DATA       read data
//  S_AXI_RRESP    out  2          00 OKAY, 10 SLVERR
//  S_AXI_RVALID   out  1          read-data valid
//  S_AXI_RREADY   in   1          read-data ready
//  STATUS_IN      in   32         value returned for word 0
//  REG_OUT        out  32*NUM_REGS  flat word i at [32*i+31:32*i]; slice 0 = 0
//  WR_PULSE       out  NUM_REGS   one-cycle strobe, bit i = word i just committed
// BEHAVIOUR
//  - Reset (async assert, sync release): all READY/VALID = 0, BRESP/RRESP = 00, RDATA = 0,
//    all registers = 0, WR_PULSE = 0; in-flight transactions are discarded.
//  - Decode: hit if BASE_ADDR <= addr < BASE_ADDR+4*NUM_REGS; idx = (addr-BASE_ADDR)>>2; addr[1:0] ignored.
//  - Write FSM, W_IDLE -> W_RESP -> W_IDLE; one write outstanding:
//    W_IDLE: AWREADY = 1 until AW is captured, WREADY = 1 until W is captured; AW and W captured
//    independently, in either order or on the same edge. Each READY drops the cycle after its handshake.
//    The edge after both are held: commit, set BVALID = 1, pulse WR_PULSE[idx], enter W_RESP.
//    Commit: each byte lane with WSTRB=1 is updated; idx 0 or miss -> no update. BRESP = SLVERR on miss,
//    OKAY otherwise (including writes to word 0, which are ignored).
//    W_RESP: hold BVALID/BRESP until BREADY; after that handshake BVALID = 0, return to W_IDLE.
//    AW/W handshakes on the same edge -> BVALID on the next cycle (one cycle of latency).
//  - Read FSM, R_IDLE -> R_DATA -> R_IDLE:
//    R_IDLE: ARREADY = 1. On AR handshake: ARREADY = 0, RVALID = 1 on the next cycle.
//    RDATA = register value before that edge (word 0 = STATUS_IN sampled at that edge).
//    RDATA = 0 with SLVERR on miss.
//    R_DATA: hold RVALID/RDATA/RRESP until RREADY. Then RVALID = 0 and ARREADY = 1 on the next cycle.
//    Maximum rate is one read per 2 cycles.
//  - The read and write FSMs are fully independent. A read and a commit to the same word on the same edge
//    return the old value.
//  - WR_PULSE is asserted only on a commit that hits words 1..NUM_REGS-1 with any WSTRB bit set.
// TESTING
//  1. Write 0x42 to 0x1014 with AW+W on the same cycle, WSTRB=F -> BVALID the next cycle, BRESP=00,
//     word 5 = 0x42, WR_PULSE[5] for 1 cycle.
//  2. W 3 cycles before AW (0x1008, 0xA5A5A5A5), BREADY held 0 for 4 cycles -> BVALID held stable,
//     no second AWREADY until the B handshake completes.
//  3. Write 0xFFFF_FFFF with WSTRB=0101 over 0x11223344 at 0x1004 -> word 1 = 0x11FF33FF.
//  4. Read 0x1000 with STATUS_IN=0xCAFE0001 -> RDATA 0xCAFE0001, RRESP 00; write 0x1000 -> OKAY,
//     no change, no WR_PULSE.
//  5. Write 0x2000 and read 0x0FFC -> BRESP=10, RRESP=10, RDATA=0, no register change.
//  6. Assert ARESETN low for 1 cycle while in W_RESP with BVALID=1 -> BVALID 0 immediately,
//     all words 0; the next write completes normally.

Source files
------------

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave register bank: word 0 reads STATUS_IN, words 1..NUM_REGS-1 are R/W with byte strobes.
// Independent write (AW/W/B) and read (AR/R) state machines, one transaction outstanding on each.
module axi4lite_reg_slave #(
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
  parameter int          NUM_REGS       = 8
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic [AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  input  logic [2:0]                    S_AXI_ARPROT,
  output logic [AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic [31:0]                   STATUS_IN,
  output logic [32*NUM_REGS-1:0]        REG_OUT,
  output logic [NUM_REGS-1:0]           WR_PULSE
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE = AXI_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(4 * NUM_REGS);

  function automatic logic addr_hit(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = a - BASE;
    return (a >= BASE) && (off < SPAN);
  endfunction

  function automatic logic [3:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    return 4'((a - BASE) >> 2);
  endfunction

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  logic [0:0]                  w_state_reg;
  logic                        aw_held_reg, w_held_reg;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_reg;
  logic [AXI_DATA_WIDTH-1:0]   wdata_reg;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_reg;
  logic                        awready_reg, wready_reg, bvalid_reg;
  logic [1:0]                  bresp_reg;
  logic [32*NUM_REGS-1:0]      regs_reg;
  logic [NUM_REGS-1:0]         wr_pulse_reg;

  logic                        aw_hs, w_hs, aw_have, w_have, commit, c_hit;
  logic [AXI_ADDR_WIDTH-1:0]   c_addr;
  logic [AXI_DATA_WIDTH-1:0]   c_data;
  logic [AXI_DATA_WIDTH/8-1:0] c_strb;
  logic [3:0]                  c_idx;
  logic [NUM_REGS-1:0]         wr_sel;

  assign aw_hs   = S_AXI_AWVALID && awready_reg;
  assign w_hs    = S_AXI_WVALID && wready_reg;
  assign aw_have = aw_held_reg || aw_hs;
  assign w_have  = w_held_reg || w_hs;
  assign commit  = (w_state_reg == W_IDLE) && aw_have && w_have;
  // A channel captured on the commit edge itself is used straight from the bus.
  assign c_addr  = aw_held_reg ? awaddr_reg : S_AXI_AWADDR;
  assign c_data  = w_held_reg ? wdata_reg : S_AXI_WDATA;
  assign c_strb  = w_held_reg ? wstrb_reg : S_AXI_WSTRB;
  assign c_hit   = addr_hit(c_addr);
  assign c_idx   = addr_idx(c_addr);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_word
      if (gi == 0) begin : g_status
        assign wr_sel[gi] = 1'b0;
      end else begin : g_rw
        assign wr_sel[gi] = commit && c_hit && (c_idx == 4'(gi)) && (|c_strb);
      end
      assign REG_OUT[32*gi +: 32] = regs_reg[32*gi +: 32];
    end
  endgenerate

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_reg <= W_IDLE;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held_reg <= 1'b1;
            awaddr_reg  <= S_AXI_AWADDR;
          end
          if (w_hs) begin
            w_held_reg <= 1'b1;
            wdata_reg  <= S_AXI_WDATA;
            wstrb_reg  <= S_AXI_WSTRB;
          end
          if (commit) begin
            w_state_reg <= W_RESP;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= c_hit ? RESP_OKAY : RESP_SLVERR;
          end else begin
            awready_reg <= !aw_have;
            wready_reg  <= !w_have;
          end
        end
        default: begin
          if (S_AXI_BREADY) begin
            w_state_reg <= W_IDLE;
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      regs_reg     <= '0;
      wr_pulse_reg <= '0;
    end else begin
      wr_pulse_reg <= wr_sel;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (c_strb[b]) regs_reg[32*i+8*b +: 8] <= c_data[8*b +: 8];
          end
        end
      end
    end
  end

  logic [0:0]                r_state_reg;
  logic                      arready_reg, rvalid_reg;
  logic [AXI_DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]                rresp_reg;
  logic [AXI_DATA_WIDTH-1:0] rd_word;
  logic [3:0]                ar_idx;
  logic                      ar_hit;

  assign ar_idx = addr_idx(S_AXI_ARADDR);
  assign ar_hit = addr_hit(S_AXI_ARADDR);

  always_comb begin
    rd_word = '0;
    if (ar_idx == 4'd0) rd_word = STATUS_IN;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ar_idx == 4'(i)) rd_word = regs_reg[32*i +: 32];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (arready_reg && S_AXI_ARVALID) begin
            r_state_reg <= R_DATA;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            rdata_reg   <= ar_hit ? rd_word : '0;
            rresp_reg   <= ar_hit ? RESP_OKAY : RESP_SLVERR;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        default: begin
          if (S_AXI_RREADY) begin
            r_state_reg <= R_IDLE;
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = rresp_reg;
  assign WR_PULSE      = wr_pulse_reg;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Randomized bench for axi4lite_reg_slave: directed bus scenarios plus random traffic,
// checked against an array model of the register map built from the address/strobe rules.
module tb_axi4lite_reg_slave;

  localparam int          NREG = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       awaddr = '0, wdata = '0, araddr = '0, status_in = '0;
  logic              awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [3:0]        wstrb = '0;
  logic [2:0]        awprot = '0, arprot = '0;
  logic              awready, wready, bvalid, arready, rvalid;
  logic [1:0]        bresp, rresp;
  logic [31:0]       rdata;
  logic [32*NREG-1:0] reg_out;
  logic [NREG-1:0]   wr_pulse;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [NREG];

  always #5 clk = ~clk;

  axi4lite_reg_slave #(
    .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .BASE_ADDR(BASE), .NUM_REGS(NREG)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWPROT(awprot),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARPROT(arprot),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .STATUS_IN(status_in), .REG_OUT(reg_out), .WR_PULSE(wr_pulse)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * NREG));
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREG; i++)
      check_eq($sformatf("%s.word%0d", tag, i), reg_out[32*i +: 32], (i == 0) ? 32'h0 : model[i]);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_d, input int w_d, input int b_d, input bit do_reset);
    bit hit;
    int idx;
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [NREG-1:0] exp_pulse;
    hit = in_range(addr);
    idx = hit ? idx_of(addr) : 0;
    exp_pulse = '0;
    if (hit && idx != 0 && strb != 4'h0) exp_pulse[idx] = 1'b1;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 100) begin
      awvalid = !aw_done && (cyc >= aw_d);
      wvalid  = !w_done && (cyc >= w_d);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      cyc++;
      if (aw_done && !w_done) begin
        check_eq("awready_dropped", 32'(awready), 32'h0);
        check_eq("bvalid_early", 32'(bvalid), 32'h0);
      end
      if (w_done && !aw_done) begin
        check_eq("wready_dropped", 32'(wready), 32'h0);
        check_eq("bvalid_early", 32'(bvalid), 32'h0);
      end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      check_eq("wr_handshake_timeout", 32'h0, 32'h1);
      return;
    end
    if (exp_pulse != '0)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    check_eq("bvalid", 32'(bvalid), 32'h1);
    check_eq("bresp", 32'(bresp), hit ? 32'h0 : 32'h2);
    check_eq("wr_pulse", 32'(wr_pulse), 32'(exp_pulse));
    check_regs("wr_regs");
    $display("WR addr=%h data=%h strb=%h bresp=%0d pulse=%b", addr, data, strb, bresp, wr_pulse);
    if (do_reset) begin
      rst_n = 1'b0;
      #1;
      check_eq("rst_bvalid", 32'(bvalid), 32'h0);
      check_eq("rst_wr_pulse", 32'(wr_pulse), 32'h0);
      check_eq("rst_awready", 32'(awready), 32'h0);
      for (int i = 0; i < NREG; i++) model[i] = '0;
      check_regs("rst_regs");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      return;
    end
    for (int k = 0; k < b_d; k++) begin
      tick();
      check_eq("bvalid_hold", 32'(bvalid), 32'h1);
      check_eq("bresp_hold", 32'(bresp), hit ? 32'h0 : 32'h2);
      check_eq("awready_in_resp", 32'(awready), 32'h0);
      check_eq("wr_pulse_once", 32'(wr_pulse), 32'h0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check_eq("bvalid_clear", 32'(bvalid), 32'h0);
    check_eq("wr_pulse_clear", 32'(wr_pulse), 32'h0);
    check_eq("awready_back", 32'(awready), 32'h1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_d);
    bit hit;
    int n;
    logic [31:0] exp_data;
    hit = in_range(addr);
    exp_data = '0;
    if (hit) exp_data = (idx_of(addr) == 0) ? status_in : model[idx_of(addr)];
    araddr = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    if (!arready) begin
      arvalid = 1'b0;
      check_eq("rd_handshake_timeout", 32'h0, 32'h1);
      return;
    end
    tick();
    arvalid = 1'b0;
    check_eq("arready_dropped", 32'(arready), 32'h0);
    check_eq("rvalid", 32'(rvalid), 32'h1);
    check_eq("rdata", rdata, exp_data);
    check_eq("rresp", 32'(rresp), hit ? 32'h0 : 32'h2);
    $display("RD addr=%h rdata=%h rresp=%0d", addr, rdata, rresp);
    for (int k = 0; k < r_d; k++) begin
      tick();
      check_eq("rvalid_hold", 32'(rvalid), 32'h1);
      check_eq("rdata_hold", rdata, exp_data);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check_eq("rvalid_clear", 32'(rvalid), 32'h0);
    check_eq("arready_back", 32'(arready), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    repeat (2) tick();
    check_eq("reset_awready", 32'(awready), 32'h0);
    check_eq("reset_wready", 32'(wready), 32'h0);
    check_eq("reset_arready", 32'(arready), 32'h0);
    check_eq("reset_bvalid", 32'(bvalid), 32'h0);
    check_eq("reset_rvalid", 32'(rvalid), 32'h0);
    check_eq("reset_rdata", rdata, 32'h0);
    check_eq("reset_wr_pulse", 32'(wr_pulse), 32'h0);
    check_regs("reset_regs");
    rst_n = 1'b1;
    tick();
    check_eq("release_awready", 32'(awready), 32'h1);
    check_eq("release_wready", 32'(wready), 32'h1);
    check_eq("release_arready", 32'(arready), 32'h1);

    axi_write(32'h1014, 32'h42, 4'hF, 0, 0, 0, 0);
    check_eq("t1_word5", reg_out[32*5 +: 32], 32'h42);
    axi_write(32'h1008, 32'hA5A5A5A5, 4'hF, 3, 0, 4, 0);
    axi_write(32'h1004, 32'h11223344, 4'hF, 0, 0, 0, 0);
    axi_write(32'h1004, 32'hFFFFFFFF, 4'h5, 0, 0, 0, 0);
    check_eq("t3_word1", reg_out[32*1 +: 32], 32'h11FF33FF);
    status_in = 32'hCAFE0001;
    axi_read(32'h1000, 0);
    axi_write(32'h1000, 32'h12345678, 4'hF, 1, 0, 0, 0);
    axi_write(32'h2000, 32'hDEADBEEF, 4'hF, 0, 2, 1, 0);
    axi_read(32'h0FFC, 1);
    axi_read(32'h1014, 2);
    axi_write(32'h1010, 32'h00001234, 4'hF, 0, 0, 0, 1);
    axi_write(32'h101C, 32'hDEADBEEF, 4'hF, 1, 2, 1, 0);
    axi_read(32'h101C, 0);

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'h2000 + 32'($urandom_range(0, 255));
        1:       a = BASE - 32'($urandom_range(1, 16));
        default: a = BASE + 32'($urandom_range(0, 4 * NREG - 1));
      endcase
      status_in = $urandom;
      if ($urandom_range(0, 1) == 0)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), 0);
      else
        axi_read(a, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
